// File: rtl/wb_regfile.sv
// W-stage writeback: result mux, 32x32 integer register file with x0 hardwired to zero,
// two asynchronous read ports and a committed-write counter. Optional macro: REGFILE_WB_BYPASS_EN.
module wb_regfile #(
  parameter  int NREGS = 32,
  parameter  int XLEN  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            RegWriteW,
  input  logic            MemtoRegW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] ComputeResultW,
  input  logic [AW-1:0]   rdW,
  input  logic [AW-1:0]   rs1D,
  input  logic [AW-1:0]   rs2D,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [XLEN-1:0] ResultW,
  output logic [31:0]     WbCountW
);

  logic [XLEN-1:0] regs [NREGS];
  logic            commit;

  always_comb begin
    ResultW = MemtoRegW ? ReadDataW : ComputeResultW;
    commit  = RegWriteW & (rdW != '0) & ~RESET;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[rdW] <= ResultW;
    end
  end

  // Counter is reassigned every edge (adding 0 when idle) so its state is always the
  // value it was last seen holding.
  always_ff @(posedge CLK) begin
    if (RESET) WbCountW <= '0;
    else       WbCountW <= WbCountW + 32'(commit);
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
`ifdef REGFILE_WB_BYPASS_EN
    if (rs1D != '0) RD1 = (commit && rs1D == rdW) ? ResultW : regs[rs1D];
    if (rs2D != '0) RD2 = (commit && rs2D == rdW) ? ResultW : regs[rs2D];
`else
    if (rs1D != '0) RD1 = regs[rs1D];
    if (rs2D != '0) RD2 = regs[rs2D];
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, randomized run against a
// behavioural register-file model, mid-stream reset and counter wrap.
module tb_wb_regfile;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ComputeResultW;
  logic [4:0]  rdW, rs1D, rs2D;
  logic [31:0] RD1, RD2, ResultW, WbCountW;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0]  model [32];
  logic [31:0]  modelCnt;

  always #5 CLK = ~CLK;

  wb_regfile #(.NREGS(32), .XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ComputeResultW(ComputeResultW), .rdW(rdW),
    .rs1D(rs1D), .rs2D(rs2D), .RD1(RD1), .RD2(RD2), .ResultW(ResultW),
    .WbCountW(WbCountW)
  );

  typedef struct {
    logic        rst, we, m2r;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] cr, dat;
    logic [31:0] expRd1, expRd2, expRes, expCnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] cr, input logic [31:0] dat,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    RESET = rst; RegWriteW = we; MemtoRegW = m2r; rdW = rd;
    ComputeResultW = cr; ReadDataW = dat; rs1D = rs1; rs2D = rs2;
  endtask

  function automatic logic [31:0] refResult();
    return MemtoRegW ? ReadDataW : ComputeResultW;
  endfunction

  function automatic logic refCommit();
    return RegWriteW && rdW != 5'd0 && !RESET;
  endfunction

  function automatic logic [31:0] refRead(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (BYP && refCommit() && rs == rdW) return refResult();
    return model[rs];
  endfunction

  // Apply the current inputs to the model at the rising edge.
  task automatic modelEdge();
    if (RESET) begin
      foreach (model[i]) model[i] = 32'd0;
      modelCnt = 32'd0;
    end else if (refCommit()) begin
      model[rdW] = refResult();
      modelCnt   = modelCnt + 32'd1;
    end
  endtask

  task automatic clockEdge();
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
  endtask

  task automatic sweepZero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs1D = 5'(i); rs2D = 5'(31 - i);
      #1;
      check({tag, "_rd1"}, RD1, 32'd0);
      check({tag, "_rd2"}, RD2, 32'd0);
    end
    check({tag, "_cnt"}, WbCountW, 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    logic [31:0] pre9;
    foreach (model[i]) model[i] = 32'd0;
    modelCnt = 32'd0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    @(negedge CLK);
    clockEdge();
    clockEdge();
    RESET = 1'b0;
    sweepZero("reset");

    pre9 = 32'h1111_1111;
    //            rst   we    m2r   rd     rs1    rs2    cr             dat            expRd1 expRd2 expRes expCnt
    vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0000_1234, 32'hDEAD_BEEF,
                32'd0, 32'd0, 32'h0000_1234, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 5'd6, 5'd5, 5'd0, 32'h0000_1234, 32'hDEAD_BEEF,
                32'h0000_1234, 32'd0, 32'hDEAD_BEEF, 32'd1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd6, 32'hFFFF_FFFF, 32'd0,
                32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd2};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd7, 32'h0000_0777, 32'd0,
                32'd0, 32'd0, 32'h0000_0777, 32'd2};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd5, 32'd0, 32'd0,
                32'd0, 32'h0000_1234, 32'd0, 32'd2};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, pre9, 32'd0,
                32'd0, 32'd0, pre9, 32'd2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 32'hAAAA_5555, 32'd0,
                BYP ? 32'hAAAA_5555 : pre9, BYP ? 32'hAAAA_5555 : pre9, 32'hAAAA_5555, 32'd3};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 32'd0, 32'd0,
                32'hAAAA_5555, 32'hAAAA_5555, 32'd0, 32'd4};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 5'd9, 32'h0000_0055, 32'd0,
                32'd0, 32'hAAAA_5555, 32'h0000_0055, 32'd4};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd9, 32'd0, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd0};

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].we, vecs[k].m2r, vecs[k].rd, vecs[k].cr, vecs[k].dat,
            vecs[k].rs1, vecs[k].rs2);
      #1;
      check($sformatf("vec%0d_rd1", k), RD1, vecs[k].expRd1);
      check($sformatf("vec%0d_rd2", k), RD2, vecs[k].expRd2);
      check($sformatf("vec%0d_res", k), ResultW, vecs[k].expRes);
      check($sformatf("vec%0d_cnt", k), WbCountW, vecs[k].expCnt);
      clockEdge();
    end

    // Randomized traffic against the model; rs often aliases rd to exercise same-cycle reads.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            rd, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
      #1;
      check("rand_rd1", RD1, refRead(rs1D));
      check("rand_rd2", RD2, refRead(rs2D));
      check("rand_res", ResultW, refResult());
      check("rand_cnt", WbCountW, modelCnt);
      clockEdge();
    end

    // Ten writes, then a reset mid-stream.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    clockEdge();
    for (int n = 1; n <= 10; n++) begin
      drive(1'b0, 1'b1, 1'b0, 5'(n), 32'h100 + 32'(n), 32'd0, 5'd0, 5'd0);
      clockEdge();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd10, 5'd1);
    #1;
    check("pre_rst_rd1", RD1, 32'h0000_010A);
    check("pre_rst_cnt", WbCountW, modelCnt);
    RESET = 1'b1;
    clockEdge();
    RESET = 1'b0;
    sweepZero("midrst");

    // Counter wrap: preload the count, then one commit.
    force dut.WbCountW = 32'hFFFF_FFFF;
    clockEdge();
    release dut.WbCountW;
    #1;
    check("wrap_preload", WbCountW, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_00C0, 32'd0, 5'd12, 5'd0);
    clockEdge();
    RegWriteW = 1'b0;
    #1;
    check("wrap_cnt", WbCountW, 32'd0);
    check("wrap_rd1", RD1, 32'h0000_00C0);
    RegWriteW = 1'b1;
    clockEdge();
    RegWriteW = 1'b0;
    #1;
    check("wrap_next", WbCountW, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
